// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and types used by the fetch stage.
package mips_pkg;

   localparam logic [5:0]  OP_J              = 6'b000010;
   localparam logic [5:0]  OP_JAL            = 6'b000011;
   localparam logic [31:0] NOP_WORD          = 32'h0000_0020;
   localparam logic [31:0] HALT_WORD_DEFAULT = 32'hB422_1820;
   localparam logic [31:0] PC_ALIGN_MASK     = 32'hFFFF_FFFC;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_t;

   // J/JAL target: top nibble of the delay-slot PC plus the word index.
   function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                               input logic [25:0] index);
      return {pc_plus4[31:28], index, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC priority mux for the fetch stage.
// Early J/JAL redirection is compiled in with FETCH_EARLY_JUMP_EN.
module fetch_next_pc
   import mips_pkg::*;
#(
   parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
   input  logic [31:0]  pc,
   input  fetch_state_t state,
   input  logic         stall,
   input  logic         redirect_valid,
   input  logic [31:0]  redirect_pc,
   input  logic [31:0]  imem_data,
   output logic [31:0]  pc_plus4,
   output logic [31:0]  next_pc
);

   logic is_jump;

   assign pc_plus4 = pc + 32'd4;

`ifdef FETCH_EARLY_JUMP_EN
   assign is_jump = (imem_data[31:26] == OP_J) || (imem_data[31:26] == OP_JAL);
`else
   assign is_jump = 1'b0;
`endif

   always_comb begin
      next_pc = pc_plus4;
      if (redirect_valid) begin
         next_pc = redirect_pc & PC_ALIGN_MASK;
      end else if (stall || state == HALTED) begin
         next_pc = pc;
      end else if (imem_data == HALT_WORD) begin
         // Freeze on the HALT word so the address stays parked on it.
         next_pc = pc;
      end else if (is_jump) begin
         next_pc = jump_target(pc_plus4, imem_data[25:0]);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC register, IF/ID register and HALT tracking.
// Define FETCH_EARLY_JUMP_EN to resolve J/JAL in fetch (see fetch_next_pc).
module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic        ifid_valid,
   output logic [31:0] ifid_inst,
   output logic [31:0] ifid_pc_plus4,
   output logic        halted
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         ifid_valid_q, ifid_valid_d;
   logic [31:0]  ifid_inst_q, ifid_inst_d;
   logic [31:0]  ifid_pc_plus4_q, ifid_pc_plus4_d;
   logic [31:0]  pc_plus4, next_pc;

   fetch_next_pc #(.HALT_WORD(HALT_WORD)) u_next_pc (
      .pc             (pc_q),
      .state          (state_q),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_data      (imem_data),
      .pc_plus4       (pc_plus4),
      .next_pc        (next_pc)
   );

   always_comb begin
      state_d         = state_q;
      pc_d            = next_pc & PC_ALIGN_MASK;
      ifid_valid_d    = ifid_valid_q;
      ifid_inst_d     = ifid_inst_q;
      ifid_pc_plus4_d = ifid_pc_plus4_q;
      if (redirect_valid) begin
         // The redirecting instruction is older than anything in IF/ID.
         state_d         = RUN;
         ifid_valid_d    = 1'b0;
         ifid_inst_d     = NOP_WORD;
         ifid_pc_plus4_d = 32'h0;
      end else if (!stall) begin
         if (state_q == HALTED) begin
            ifid_valid_d    = 1'b0;
            ifid_inst_d     = NOP_WORD;
            ifid_pc_plus4_d = 32'h0;
         end else begin
            ifid_valid_d    = 1'b1;
            ifid_inst_d     = imem_data;
            ifid_pc_plus4_d = pc_plus4;
            if (imem_data == HALT_WORD) state_d = HALTED;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= RUN;
         pc_q            <= RESET_PC & PC_ALIGN_MASK;
         ifid_valid_q    <= 1'b0;
         ifid_inst_q     <= NOP_WORD;
         ifid_pc_plus4_q <= 32'h0;
      end else begin
         state_q         <= state_d;
         pc_q            <= pc_d;
         ifid_valid_q    <= ifid_valid_d;
         ifid_inst_q     <= ifid_inst_d;
         ifid_pc_plus4_q <= ifid_pc_plus4_d;
      end
   end

   assign imem_addr     = pc_q;
   assign ifid_valid    = ifid_valid_q;
   assign ifid_inst     = ifid_inst_q;
   assign ifid_pc_plus4 = ifid_pc_plus4_q;
   assign halted        = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small combinational instruction memory.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset, stall, redirect_valid;
   logic [31:0] redirect_pc, imem_addr, imem_data, ifid_inst, ifid_pc_plus4;
   logic        ifid_valid, halted;
   logic [31:0] mem [0:63];
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   assign imem_data = mem[imem_addr[7:2]];

   fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .ifid_valid     (ifid_valid),
      .ifid_inst      (ifid_inst),
      .ifid_pc_plus4  (ifid_pc_plus4),
      .halted         (halted)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ifid(input string tag, input logic v, input logic [31:0] inst,
                           input logic [31:0] pc4);
      chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, v});
      chk({tag, ".inst"}, ifid_inst, inst);
      chk({tag, ".pc4"}, ifid_pc_plus4, pc4);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h2000_0000 | i;
      mem[0]  = 32'h8C01_0000;
      mem[1]  = 32'h3402_0004;
      mem[2]  = 32'h2003_FFFE;
      mem[29] = 32'h0800_0020;  // 0x74: J 0x80
      mem[33] = 32'hB422_1820;  // 0x84: HALT

      reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      step(); step();
      chk("rst.addr", imem_addr, 32'h0);
      chk_ifid("rst", 1'b0, 32'h20, 32'h0);
      chk("rst.halted", {31'd0, halted}, 32'h0);

      reset = 1'b0;
      step();
      chk("seq1.addr", imem_addr, 32'h4);
      chk_ifid("seq1", 1'b1, 32'h8C01_0000, 32'h4);
      step();
      chk("seq2.addr", imem_addr, 32'h8);
      chk_ifid("seq2", 1'b1, 32'h3402_0004, 32'h8);
      step(); step();
      chk("pre_stall.addr", imem_addr, 32'h10);
      chk_ifid("pre_stall", 1'b1, 32'h2000_0003, 32'h10);

      stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("stall.addr", imem_addr, 32'h10);
         chk_ifid("stall", 1'b1, 32'h2000_0003, 32'h10);
      end
      stall = 1'b0;
      step();
      chk("unstall.addr", imem_addr, 32'h14);
      chk_ifid("unstall", 1'b1, 32'h2000_0004, 32'h14);

      redirect_valid = 1'b1; redirect_pc = 32'h64;
      step();
      redirect_valid = 1'b0;
      chk("redir64.addr", imem_addr, 32'h64);
      // Redirect together with stall; low address bits must be dropped.
      redirect_valid = 1'b1; redirect_pc = 32'h6F; stall = 1'b1;
      step();
      redirect_valid = 1'b0; stall = 1'b0;
      chk("redir6c.addr", imem_addr, 32'h6C);
      chk_ifid("redir6c", 1'b0, 32'h20, 32'h0);
      step();
      chk("after6c.addr", imem_addr, 32'h70);
      chk_ifid("after6c", 1'b1, 32'h2000_001B, 32'h70);
      step();
      chk("pre_j.addr", imem_addr, 32'h74);
      step();
`ifdef FETCH_EARLY_JUMP_EN
      chk("j.addr", imem_addr, 32'h80);
`else
      chk("j.addr", imem_addr, 32'h78);
`endif
      chk_ifid("j", 1'b1, 32'h0800_0020, 32'h78);

      redirect_valid = 1'b1; redirect_pc = 32'h84;
      step();
      redirect_valid = 1'b0;
      chk("halt_fetch.addr", imem_addr, 32'h84);
      chk("halt_fetch.halted", {31'd0, halted}, 32'h0);
      step();
      chk_ifid("halt_cap", 1'b1, 32'hB422_1820, 32'h88);
      chk("halt_cap.halted", {31'd0, halted}, 32'h1);
      chk("halt_cap.addr", imem_addr, 32'h84);
      step();
      chk_ifid("halted_bub", 1'b0, 32'h20, 32'h0);
      chk("halted_bub.addr", imem_addr, 32'h84);
      chk("halted_bub.halted", {31'd0, halted}, 32'h1);
      redirect_valid = 1'b1; redirect_pc = 32'h20;
      step();
      redirect_valid = 1'b0;
      chk("unhalt.halted", {31'd0, halted}, 32'h0);
      chk("unhalt.addr", imem_addr, 32'h20);
      step();
      chk("resume.addr", imem_addr, 32'h24);
      chk_ifid("resume", 1'b1, 32'h2000_0008, 32'h24);

      redirect_valid = 1'b1; redirect_pc = 32'h84;
      step();
      redirect_valid = 1'b0;
      step(); step();
      chk("halt2.halted", {31'd0, halted}, 32'h1);
      stall = 1'b1; reset = 1'b1;
      step();
      stall = 1'b0; reset = 1'b0;
      chk("rst_halt.addr", imem_addr, 32'h0);
      chk("rst_halt.halted", {31'd0, halted}, 32'h0);
      chk("rst_halt.valid", {31'd0, ifid_valid}, 32'h0);

      // PC+4 wrap at the top of the address space.
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      chk("wrap_top.addr", imem_addr, 32'hFFFF_FFFC);
      step();
      chk("wrap.addr", imem_addr, 32'h0);
      chk_ifid("wrap", 1'b1, 32'h2000_003F, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
